multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// pc_src / wb_sel selects, and the opcode-class decoder.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_HALT    = 3'd6;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILL
  } insn_cls_t;

  function automatic insn_cls_t decode_op(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      default:   return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory handshake bundle between the multicycle controller (master)
// and its environment (slave).
interface multicycle_ctrl_if;

  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       branch_taken;
  logic       imem_req;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       alu_src_imm;
  logic       dmem_req;
  logic       dmem_we;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       retire;
  logic [2:0] state;
  logic       bus_err;
  logic       illegal_insn;

  modport master (
    input  opcode, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_we, pc_we, pc_src, alu_src_imm, dmem_req, dmem_we,
           reg_we, wb_sel, retire, state, bus_err, illegal_insn
  );

  modport slave (
    output opcode, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_we, pc_we, pc_src, alu_src_imm, dmem_req, dmem_we,
           reg_we, wb_sel, retire, state, bus_err, illegal_insn
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory wait-timeout detection.
// Optional: define ILLEGAL_TRAP_EN to halt on illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int              CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(MAX_WAIT - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  insn_cls_t     cls;
  insn_cls_t     dec_cls;
  logic [CW-1:0] waitcnt;
  logic          wait_last;
  logic          pending;
  logic          set_bus_err;
  logic          bus_err_q;

  assign dec_cls   = decode_op(bus.opcode);
  assign wait_last = (waitcnt == WAIT_LAST);
  assign pending   = ((state == ST_FETCH) && !bus.imem_ready) ||
                     ((state == ST_MEM)   && !bus.dmem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cls     <= CLS_R;
      waitcnt <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE)
        cls <= dec_cls;
      // Leaving FETCH/MEM always passes through a non-pending cycle, so clearing here covers entry.
      if (pending)
        waitcnt <= waitcnt + 1'b1;
      else
        waitcnt <= '0;
      if (set_bus_err)
        bus_err_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic set_ill;
  logic ill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ill_q <= 1'b0;
    else if (set_ill)
      ill_q <= 1'b1;
  end

  assign bus.illegal_insn = ill_q;
`else
  assign bus.illegal_insn = 1'b0;
`endif

  assign bus.state   = state;
  assign bus.bus_err = bus_err_q;

  always_comb begin
    state_nxt       = state;
    set_bus_err     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    set_ill         = 1'b0;
`endif
    bus.imem_req    = 1'b0;
    bus.ir_we       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_src      = PC_PLUS4;
    bus.alu_src_imm = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.reg_we      = 1'b0;
    bus.wb_sel      = WB_ALU;
    bus.retire      = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_we = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_last) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end
      end
      ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (dec_cls == CLS_ILL) begin
          set_ill   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_EXECUTE;
        end
`else
        // Illegal opcodes skip straight to WB, which retires them as a NOP.
        state_nxt = (dec_cls == CLS_ILL) ? ST_WB : ST_EXECUTE;
`endif
      end
      ST_EXECUTE: begin
        bus.alu_src_imm = (cls == CLS_I) || (cls == CLS_LOAD) ||
                          (cls == CLS_STORE) || (cls == CLS_JALR);
        case (cls)
          CLS_BRANCH: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = bus.branch_taken ? PC_TARGET : PC_PLUS4;
            bus.retire = 1'b1;
            state_nxt  = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (cls == CLS_STORE);
        if (bus.dmem_ready) begin
          if (cls == CLS_STORE) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
            state_nxt  = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wait_last) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end
      end
      ST_WB: begin
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
        state_nxt  = ST_FETCH;
        case (cls)
          CLS_R, CLS_I: bus.reg_we = 1'b1;
          CLS_LOAD: begin
            bus.reg_we = 1'b1;
            bus.wb_sel = WB_MEM;
          end
          CLS_JAL: begin
            bus.reg_we = 1'b1;
            bus.wb_sel = WB_PC4;
            bus.pc_src = PC_TARGET;
          end
          CLS_JALR: begin
            bus.reg_we = 1'b1;
            bus.wb_sel = WB_PC4;
            bus.pc_src = PC_JALR;
          end
          default: bus.reg_we = 1'b0;
        endcase
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl; inputs change 1 ns after
// the rising edge and outputs are compared on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OPLD  = 7'b0000011;
  localparam logic [6:0] OPST  = 7'b0100011;
  localparam logic [6:0] OPBR  = 7'b1100011;
  localparam logic [6:0] OPJL  = 7'b1101111;
  localparam logic [6:0] OPJR  = 7'b1100111;
  localparam logic [6:0] OPBAD = 7'b0110111;

  typedef struct {
    logic [6:0]  opcode;
    logic        iready;
    logic        dready;
    logic        taken;
    logic [16:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MAX_WAIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Expected word: {state, imem_req, ir_we, pc_we, pc_src, alu_src_imm, dmem_req, dmem_we, reg_we, wb_sel, retire, bus_err, illegal_insn}
  function automatic logic [16:0] mk(input int st, input int ireq, input int irwe, input int pcwe,
                                     input int pcs, input int alui, input int dreq, input int dwe,
                                     input int rwe, input int wbs, input int ret, input int berr, input int ill);
    return {3'(st), 1'(ireq), 1'(irwe), 1'(pcwe), 2'(pcs), 1'(alui), 1'(dreq), 1'(dwe),
            1'(rwe), 2'(wbs), 1'(ret), 1'(berr), 1'(ill)};
  endfunction

  function automatic logic [16:0] getOuts();
    return {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_imm,
            bus.dmem_req, bus.dmem_we, bus.reg_we, bus.wb_sel, bus.retire, bus.bus_err, bus.illegal_insn};
  endfunction

  function automatic vec_t vec(input logic [6:0] op, input int ir, input int dr, input int tk, input logic [16:0] e);
    vec_t v;
    v.opcode = op;
    v.iready = 1'(ir);
    v.dready = 1'(dr);
    v.taken  = 1'(tk);
    v.exp    = e;
    return v;
  endfunction

  task automatic add(input logic [6:0] op, input int ir, input int dr, input int tk, input logic [16:0] e);
    tbl.push_back(vec(op, ir, dr, tk, e));
  endtask

  task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    bus.opcode       = v.opcode;
    bus.imem_ready   = v.iready;
    bus.dmem_ready   = v.dready;
    bus.branch_taken = v.taken;
    @(negedge clk);
    checkOutput(name, getOuts(), v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst              = 1'b0;
    bus.opcode       = 7'd0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // R, I, LOAD (2 fetch waits, 3 mem waits), STORE, BRANCH x2, JAL, JALR back to back.
    add(OPR, 1, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPR, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPR, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPR, 1, 0, 0, mk(3,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPR, 1, 0, 0, mk(5,0,0,1,0,0,0,0,1,0,1,0,0));
    add(OPI, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPI, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPI, 1, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    add(OPI, 1, 0, 0, mk(5,0,0,1,0,0,0,0,1,0,1,0,0));
    add(OPLD, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0));
    add(OPLD, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(4,0,0,0,0,0,1,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(4,0,0,0,0,0,1,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(4,0,0,0,0,0,1,0,0,0,0,0,0));
    add(OPLD, 0, 1, 0, mk(4,0,0,0,0,0,1,0,0,0,0,0,0));
    add(OPLD, 0, 0, 0, mk(5,0,0,1,0,0,0,0,1,1,1,0,0));
    add(OPST, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPST, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPST, 1, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    add(OPST, 1, 1, 0, mk(4,0,0,1,0,0,1,1,0,0,1,0,0));
    add(OPBR, 1, 0, 1, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPBR, 1, 0, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPBR, 1, 0, 1, mk(3,0,0,1,1,0,0,0,0,0,1,0,0));
    add(OPBR, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPBR, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPBR, 1, 0, 0, mk(3,0,0,1,0,0,0,0,0,0,1,0,0));
    add(OPJL, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPJL, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPJL, 1, 0, 0, mk(3,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPJL, 1, 0, 0, mk(5,0,0,1,1,0,0,0,1,2,1,0,0));
    add(OPJR, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0));
    add(OPJR, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(OPJR, 1, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    add(OPJR, 1, 0, 0, mk(5,0,0,1,2,0,0,0,1,2,1,0,0));

    $display("[TB] reset and table of %0d vectors", tbl.size());
    rst = 1'b0;
    bus.opcode = 7'd0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.branch_taken = 1'b1;
    #12;
    checkOutput("reset state", getOuts(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i], $sformatf("tbl[%0d]", i));

    // Illegal opcode straight after JALR.
    applyStimulus(vec(OPBAD, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0)), "illegal fetch");
    applyStimulus(vec(OPBAD, 1, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0)), "illegal decode");
`ifdef ILLEGAL_TRAP_EN
    applyStimulus(vec(OPBAD, 1, 0, 0, mk(6,0,0,0,0,0,0,0,0,0,0,0,1)), "illegal halt");
    applyStimulus(vec(OPBAD, 1, 1, 0, mk(6,0,0,0,0,0,0,0,0,0,0,0,1)), "illegal halt hold");
`else
    applyStimulus(vec(OPBAD, 1, 0, 0, mk(5,0,0,1,0,0,0,0,0,0,1,0,0)), "illegal nop wb");
    applyStimulus(vec(OPBAD, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0)), "illegal next fetch");
`endif

    // Ready arriving in the last allowed FETCH cycle completes normally.
    doReset();
    applyStimulus(vec(OPR, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0)), "edge idle");
    for (int k = 1; k <= 15; k++)
      applyStimulus(vec(OPR, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0)), $sformatf("edge fetch %0d", k));
    applyStimulus(vec(OPR, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0)), "edge fetch 16 ready");
    applyStimulus(vec(OPR, 0, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0)), "edge decode");

    // imem_ready never arrives: HALT after 16 request cycles.
    doReset();
    applyStimulus(vec(OPR, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0)), "to idle");
    for (int k = 1; k <= 16; k++)
      applyStimulus(vec(OPR, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0)), $sformatf("to fetch %0d", k));
    applyStimulus(vec(OPR, 1, 1, 1, mk(6,0,0,0,0,0,0,0,0,0,0,1,0)), "to halt");
    applyStimulus(vec(OPR, 1, 1, 1, mk(6,0,0,0,0,0,0,0,0,0,0,1,0)), "to halt hold");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("halt async reset", getOuts(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // Reset asserted in the middle of a pending LOAD access.
    doReset();
    applyStimulus(vec(OPLD, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0)), "mr idle");
    applyStimulus(vec(OPLD, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0)), "mr fetch");
    applyStimulus(vec(OPLD, 0, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0)), "mr decode");
    applyStimulus(vec(OPLD, 0, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0)), "mr execute");
    #2;
    checkOutput("mr in mem", getOuts(), mk(4,0,0,0,0,0,1,0,0,0,0,0,0));
    rst = 1'b0;
    #1;
    checkOutput("mr async reset", getOuts(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(vec(OPLD, 1, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0)), "mr post idle");
    applyStimulus(vec(OPLD, 1, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0,0)), "mr post fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
